adc_model_multi: RTL and testbench

// - Clock-synchronous, multi-channel simulation model of an SPI ADC (conversion + register-access modes).
// - Stands in for NUM_CH simultaneously sampling channels behind one cnv/csn/sck bus; feeds readout-engine benches.
// - Successor of the single-channel model: per-channel SDO lanes, parametrised word width, snapshot of sample data.

---
 rtl/adc_model_pkg.sv | 27 ++
 rtl/adc_model_lane_shifter.sv | 87 ++++++++
 rtl/adc_model_multi.sv | 176 +++++++++++++++++
 tb/tb_adc_model_multi.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_model_pkg.sv
// rtl/adc_model_pkg.sv - shared types and constants for the multi-channel SPI ADC model
// Contents: device mode and FSM state enums, lane-mode codes, register addresses.
package adc_model_pkg;

  typedef enum logic {
    REG_ACCESS = 1'b0,
    CNV        = 1'b1
  } device_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    READY   = 2'd2,
    SHIFT   = 2'd3
  } adc_state_t;

  localparam logic [1:0]  LaneModeOne  = 2'b00;
  localparam logic [1:0]  LaneModeTwo  = 2'b01;
  localparam logic [1:0]  LaneModeFour = 2'b10;

  localparam logic [14:0] ExitReg      = 15'h0014;
  localparam logic [14:0] ModeReg      = 15'h0020;

  // Top three command bits that switch the device into register access
  localparam logic [2:0]  RegAccessKey = 3'b101;

endpackage

// File: rtl/adc_model_lane_shifter.sv
// rtl/adc_model_lane_shifter.sv - per-channel shadow word and 4-lane MSB-first serialiser
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load           capture load_word into the shadow, remaining bits = DATA_WIDTH
//   load_word      sample to snapshot
//   shift          emit the next group of 1/2/4 bits onto the lanes
//   clr            force the lanes to 0 (abort / end of readout)
//   lane_md        lane mode code (00/01/10 -> 1/2/4 lanes)
//   sdo            4 output lanes, lane 0 carries the most significant bit of each group
//   idx_zero       no bits left to shift
module adc_model_lane_shifter
  import adc_model_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic                  shift,
  input  logic                  clr,
  input  logic [1:0]            lane_md,
  output logic [3:0]            sdo,
  output logic                  idx_zero
);

  localparam int IdxW = $clog2(DATA_WIDTH + 1);

  // The shadow is shifted left as it is consumed, so the next bit to send is
  // always at the top; idx only tracks how many bits remain.
  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] shadow_n;
  logic [IdxW-1:0]       idx;
  logic [IdxW-1:0]       idx_n;
  logic [IdxW-1:0]       lane_w;
  logic [3:0]            sdo_n;

  always_comb begin
    lane_w   = IdxW'(1);
    shadow_n = shadow << 1;
    case (lane_md)
      LaneModeTwo: begin
        lane_w   = IdxW'(2);
        shadow_n = shadow << 2;
      end
      LaneModeFour: begin
        lane_w   = IdxW'(4);
        shadow_n = shadow << 4;
      end
      default: begin
        lane_w   = IdxW'(1);
        shadow_n = shadow << 1;
      end
    endcase

    sdo_n    = '0;
    sdo_n[0] = shadow[DATA_WIDTH-1];
    if (lane_w >= IdxW'(2)) sdo_n[1] = shadow[DATA_WIDTH-2];
    if (lane_w >= IdxW'(4)) begin
      sdo_n[2] = shadow[DATA_WIDTH-3];
      sdo_n[3] = shadow[DATA_WIDTH-4];
    end

    // Saturate so a lane-mode change mid-word can never wrap the count
    idx_n = (idx > lane_w) ? idx - lane_w : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      idx    <= '0;
      sdo    <= '0;
    end else if (load) begin
      shadow <= load_word;
      idx    <= IdxW'(DATA_WIDTH);
    end else if (clr) begin
      sdo    <= '0;
    end else if (shift) begin
      sdo    <= sdo_n;
      shadow <= shadow_n;
      idx    <= idx_n;
    end
  end

  assign idx_zero = (idx == '0);

endmodule

// File: rtl/adc_model_multi.sv
// rtl/adc_model_multi.sv - clock-synchronous multi-channel SPI ADC simulation model
// Optional feature macro: ADC_MODEL_MULTI_RAMP_EN (per-channel ramp counters replace test_pattern).
// Ports:
//   clk            model clock, at least 4x the sck frequency
//   rst            synchronous active-high reset
//   cnv            conversion start, rising edge
//   busy           high while converting
//   sck, csn, sdi  SPI clock, active-low select, command input
//   sdo            NUM_CH*4 lanes, channel c owns sdo[4c+3:4c]
//   test_pattern   per-channel sample source, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   reg_cmd        last 24 SDI bits shifted in
//   lane_md        current lane mode
module adc_model_multi
  import adc_model_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNV_CYCLES = 282
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cnv,
  output logic                         busy,
  input  logic                         sck,
  input  logic                         csn,
  input  logic                         sdi,
  output logic [NUM_CH*4-1:0]          sdo,
  input  logic [NUM_CH*DATA_WIDTH-1:0] test_pattern,
  output logic [23:0]                  reg_cmd,
  output logic [1:0]                   lane_md
);

  localparam int CntW = $clog2(CNV_CYCLES);

  logic cnv_q, cnv_p, sck_q, sck_p, csn_q, csn_p, sdi_q;
  logic cnv_rise, sck_rise, csn_fall, csn_rise;

  adc_state_t        state, state_n;
  device_mode_t      mode;
  logic [CntW-1:0]   cnt;
  logic              start, load, shift, clr;
  logic [NUM_CH*4-1:0] lanes;
  logic [NUM_CH-1:0] idx_zero;

  // Edges compare the registered input against its previous registered value
  assign cnv_rise = cnv_q & ~cnv_p;
  assign sck_rise = sck_q & ~sck_p;
  assign csn_fall = ~csn_q & csn_p;
  assign csn_rise = csn_q & ~csn_p;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    clr     = 1'b0;
    case (state)
      IDLE: begin
        if (cnv_rise) begin
          start   = 1'b1;
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        // cnv edges here are ignored; the counter keeps running
        if (cnt == CntW'(CNV_CYCLES - 1)) begin
          load    = 1'b1;
          state_n = READY;
        end
      end
      READY: begin
        if (cnv_rise) begin
          start   = 1'b1;
          clr     = 1'b1;
          state_n = CONVERT;
        end else if (csn_fall && mode == CNV) begin
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnv_rise) begin
          start   = 1'b1;
          clr     = 1'b1;
          state_n = CONVERT;
        end else if (sck_rise && !csn_q && mode == CNV) begin
          if (&idx_zero) begin
            clr     = 1'b1;
            state_n = IDLE;
          end else begin
            shift   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnv_q   <= 1'b0;
      cnv_p   <= 1'b0;
      sck_q   <= 1'b0;
      sck_p   <= 1'b0;
      csn_q   <= 1'b1;
      csn_p   <= 1'b1;
      sdi_q   <= 1'b0;
      cnt     <= '0;
      mode    <= CNV;
      reg_cmd <= '0;
      lane_md <= LaneModeOne;
    end else begin
      cnv_q <= cnv;
      cnv_p <= cnv_q;
      sck_q <= sck;
      sck_p <= sck_q;
      csn_q <= csn;
      csn_p <= csn_q;
      sdi_q <= sdi;

      if (start)                 cnt <= '0;
      else if (state == CONVERT) cnt <= cnt + CntW'(1);

      if (csn_fall)               reg_cmd <= '0;
      else if (sck_rise && !csn_q) reg_cmd <= {reg_cmd[22:0], sdi_q};

      if (csn_rise) begin
        if (reg_cmd[23:21] == RegAccessKey) begin
          mode <= REG_ACCESS;
        end else if (mode == REG_ACCESS) begin
          // Lane code 2'b11 is reserved and leaves the current mode in place
          if (reg_cmd[23:8] == {1'b0, ModeReg} && reg_cmd[7:6] != 2'b11)
            lane_md <= reg_cmd[7:6];
          else if (reg_cmd[23:8] == {1'b0, ExitReg} && reg_cmd[0])
            mode <= CNV;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] src;
`ifdef ADC_MODEL_MULTI_RAMP_EN
    logic [DATA_WIDTH-1:0] ramp_q;
    always_ff @(posedge clk) begin
      if (rst)       ramp_q <= DATA_WIDTH'(c);
      else if (load) ramp_q <= ramp_q + DATA_WIDTH'(NUM_CH);
    end
    assign src = ramp_q;
`else
    assign src = test_pattern[c*DATA_WIDTH +: DATA_WIDTH];
`endif
    adc_model_lane_shifter #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_word(src),
      .shift    (shift),
      .clr      (clr),
      .lane_md  (lane_md),
      .sdo      (lanes[4*c +: 4]),
      .idx_zero (idx_zero[c])
    );
  end

  assign busy = (state == CONVERT);
  // Register-access mode never drives data, even if a readout was interrupted
  assign sdo  = (mode == CNV) ? lanes : '0;

endmodule

// File: tb/tb_adc_model_multi.sv
// tb/tb_adc_model_multi.sv - self-checking bench for adc_model_multi
`timescale 1ns/1ps
module tb_adc_model_multi;

  localparam int NUM_CH     = 2;
  localparam int DW         = 32;
  localparam int CNV_CYCLES = 282;

  logic                 clk = 1'b0;
  logic                 rst, cnv, sck, csn, sdi;
  logic                 busy;
  logic [NUM_CH*4-1:0]  sdo;
  logic [NUM_CH*DW-1:0] tp;
  logic [23:0]          reg_cmd;
  logic [1:0]           lane_md;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the word each channel should read out next
  logic [DW-1:0] exp_word [NUM_CH];
  int            conv_done = 0;

  adc_model_multi #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNV_CYCLES(CNV_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cnv(cnv), .busy(busy), .sck(sck), .csn(csn),
    .sdi(sdi), .sdo(sdo), .test_pattern(tp), .reg_cmd(reg_cmd), .lane_md(lane_md)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sck_pulse();
    sck = 1'b1; tick(4);
    sck = 1'b0; tick(4);
  endtask

  task automatic write_cmd(input logic [23:0] cmd);
    csn = 1'b0; tick(4);
    for (int i = 23; i >= 0; i--) begin
      sdi = cmd[i];
      sck_pulse();
    end
    sdi = 1'b0;
    csn = 1'b1; tick(6);
    check("reg_cmd", reg_cmd, cmd);
  endtask

  task automatic set_lane(input logic [1:0] m);
    write_cmd(24'hA00000);
    write_cmd({16'h0020, m, 6'b0});
    write_cmd(24'h001401);
    check("lane_md", lane_md, m);
  endtask

  task automatic start_cnv();
    cnv = 1'b1; tick(2);
    cnv = 1'b0;
  endtask

  task automatic capture();
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef ADC_MODEL_MULTI_RAMP_EN
      exp_word[c] = DW'(c + NUM_CH * conv_done);
`else
      exp_word[c] = tp[c*DW +: DW];
`endif
    end
    conv_done++;
  endtask

  task automatic wait_conv(input bit chk_width, input bit retrig);
    int n;
    n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    check("busy_rise", busy, 1);
    n = 0;
    while (busy && n < 4*CNV_CYCLES) begin
      tick(1); n++;
      if (retrig && n == 100) cnv = 1'b1;
      if (retrig && n == 102) cnv = 1'b0;
    end
    if (chk_width) check("busy_width", n, CNV_CYCLES);
    else           check("busy_fall", busy, 0);
    capture();
  endtask

  // Reads one full word per channel with w lanes, optionally deasserting csn
  // before pulse pause_at, then one extra sck that must end the readout.
  task automatic readout(input int w, input int pause_at);
    logic [DW-1:0] got [NUM_CH];
    logic          stray;
    stray = 1'b0;
    for (int c = 0; c < NUM_CH; c++) got[c] = '0;
    csn = 1'b0; tick(4);
    for (int p = 0; p < DW/w; p++) begin
      if (p == pause_at) begin
        csn = 1'b1; tick(6);
        csn = 1'b0; tick(4);
      end
      sck_pulse();
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < 4; k++)
          if (k < w) got[c] = {got[c][DW-2:0], sdo[4*c+k]};
          else       stray  = stray | sdo[4*c+k];
    end
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("rd_w%0d_ch%0d", w, c), got[c], exp_word[c]);
    check("unused_lanes", stray, 0);
    sck_pulse();
    check("sdo_end", sdo, 0);
    csn = 1'b1; tick(6);
  endtask

  initial begin
    logic [1:0] m;
    int         w;
    int         pause;

    rst = 1'b1; cnv = 1'b0; sck = 1'b0; csn = 1'b1; sdi = 1'b0; tp = '0;
    tick(4);
    check("rst_busy", busy, 0);
    check("rst_sdo", sdo, 0);
    check("rst_reg_cmd", reg_cmd, 0);
    check("rst_lane_md", lane_md, 0);
    rst = 1'b0; tick(2);

    // Single-lane readout of the reference pattern
    tp = {32'hA5A5_0F0F, 32'h1234_5678};
    start_cnv(); wait_conv(1, 0);
    readout(1, -1);

    // Snapshot: source changes after busy falls must not reach the readout
    for (int c = 0; c < NUM_CH; c++) tp[c*DW +: DW] = $urandom;
    start_cnv(); wait_conv(1, 0);
    tp = '0;
    readout(1, -1);

    // Retrigger inside CONVERT is ignored
    for (int c = 0; c < NUM_CH; c++) tp[c*DW +: DW] = $urandom;
    start_cnv(); wait_conv(1, 1);
    readout(1, 5);

    // Reserved lane code, then 4-lane mode
    write_cmd(24'hA00000);
    write_cmd(24'h0020C0);
    check("lane_md_reserved", lane_md, 0);
    write_cmd(24'h002080);
    check("lane_md_four", lane_md, 2'b10);
    write_cmd(24'h001401);
    tp = {32'h0BAD_F00D, 32'h1234_5678};
    start_cnv(); wait_conv(1, 0);
    readout(4, -1);

    // Randomized lane modes with random csn pauses
    for (int it = 0; it < 4; it++) begin
      m = 2'($urandom_range(0, 2));
      w = 1 << m;
      set_lane(m);
      for (int c = 0; c < NUM_CH; c++) tp[c*DW +: DW] = $urandom;
      start_cnv(); wait_conv(1, 0);
      pause = (it % 2 == 1) ? $urandom_range(1, DW/w - 1) : -1;
      readout(w, pause);
    end

    // Abort mid-readout with a new conversion
    set_lane(LANE_ONE());
    for (int c = 0; c < NUM_CH; c++) tp[c*DW +: DW] = $urandom;
    start_cnv(); wait_conv(1, 0);
    csn = 1'b0; tick(4);
    for (int p = 0; p < 10; p++) sck_pulse();
    start_cnv(); tick(4);
    check("abort_sdo", sdo, 0);
    check("abort_busy", busy, 1);
    csn = 1'b1;
    for (int c = 0; c < NUM_CH; c++) tp[c*DW +: DW] = $urandom;
    wait_conv(0, 0);
    readout(1, -1);

    // Reset in the middle of a conversion while in register access
    write_cmd(24'hA00000);
    write_cmd(24'h002080);
    start_cnv(); tick(50);
    rst = 1'b1; tick(1);
    check("rstmid_busy", busy, 0);
    check("rstmid_lane_md", lane_md, 0);
    check("rstmid_sdo", sdo, 0);
    check("rstmid_reg_cmd", reg_cmd, 0);
    rst = 1'b0; conv_done = 0; tick(2);
    for (int c = 0; c < NUM_CH; c++) tp[c*DW +: DW] = $urandom;
    start_cnv(); wait_conv(1, 0);
    readout(1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [1:0] LANE_ONE();
    return 2'b00;
  endfunction

endmodule
